// File: rtl/w_forward_pkg.sv
// rtl/w_forward_pkg.sv - shared field widths, packet type codes and width helpers for w_forward_packer
package w_forward_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 1;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;

    localparam int AW_FIX_W = LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W + QOS_W + REGION_W;
    // Bit offset of AWLEN above AWUSER inside the packed command word
    localparam int LEN_OFS  = REGION_W + QOS_W + PROT_W + CACHE_W + LOCK_W + BURST_W + SIZE_W;

    localparam logic PKT_CMD = 1'b1;
    localparam logic PKT_DAT = 1'b0;

    // The command field keeps 4 zero bits of headroom above the 29 fixed AW bits
    function automatic int cmd_w(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + user_w + 33;
    endfunction

    function automatic int dat_w(input int data_w, input int user_w);
        return data_w + data_w / 8 + user_w + 1;
    endfunction

    function automatic int pkt_w(input int id_w, input int addr_w, input int data_w, input int user_w);
        int c;
        int d;
        c = cmd_w(id_w, addr_w, user_w);
        d = dat_w(data_w, user_w);
        return ((c > d) ? c : d) + 1;
    endfunction

endpackage

// File: rtl/w_forward_packer_aw_cmd_fifo.sv
// rtl/w_forward_packer_aw_cmd_fifo.sv - synchronous AW command FIFO with full/empty flags and level count
module aw_cmd_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted as valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/w_forward_packer.sv
// rtl/w_forward_packer.sv - serialises AXI4 AW/W onto one tagged packet stream framed by AWLEN
module w_forward_packer
    import w_forward_pkg::*;
#(
    parameter int ID_W     = 8,
    parameter int ADDR_W   = 36,
    parameter int DATA_W   = 64,
    parameter int USER_W   = 4,
    parameter int AW_DEPTH = 4
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic [ID_W-1:0]                             AWID,
    input  logic [ADDR_W-1:0]                           AWADDR,
    input  logic [LEN_W-1:0]                            AWLEN,
    input  logic [SIZE_W-1:0]                           AWSIZE,
    input  logic [BURST_W-1:0]                          AWBURST,
    input  logic [LOCK_W-1:0]                           AWLOCK,
    input  logic [CACHE_W-1:0]                          AWCACHE,
    input  logic [PROT_W-1:0]                           AWPROT,
    input  logic [QOS_W-1:0]                            AWQOS,
    input  logic [REGION_W-1:0]                         AWREGION,
    input  logic [USER_W-1:0]                           AWUSER,
    input  logic                                        AWVALID,
    output logic                                        AWREADY,
    input  logic [DATA_W-1:0]                           WDATA,
    input  logic [DATA_W/8-1:0]                         WSTRB,
    input  logic                                        WLAST,
    input  logic [USER_W-1:0]                           WUSER,
    input  logic                                        WVALID,
    output logic                                        WREADY,
    output logic [pkt_w(ID_W, ADDR_W, DATA_W, USER_W)-1:0] DATA,
    output logic                                        VALID,
    input  logic                                        READY,
    output logic [$clog2(AW_DEPTH):0]                   AW_LEVEL,
    output logic                                        ERR
);

    localparam int CMD_W    = cmd_w(ID_W, ADDR_W, USER_W);
    localparam int DAT_W    = dat_w(DATA_W, USER_W);
    localparam int PKT_W    = pkt_w(ID_W, ADDR_W, DATA_W, USER_W);
    localparam int AW_RAW_W = ID_W + ADDR_W + AW_FIX_W + USER_W;

    localparam logic [0:0] ST_CMD = 1'b0;
    localparam logic [0:0] ST_DAT = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] beats;
    logic             valid_q;
    logic [PKT_W-1:0] data_q;
    logic             err_q;

    logic [AW_RAW_W-1:0] aw_raw;
    logic [CMD_W-1:0]    aw_word;
    logic [CMD_W-1:0]    cmd_word;
    logic [DAT_W-1:0]    dat_raw;
    logic [PKT_W-1:0]    cmd_pkt;
    logic [PKT_W-1:0]    dat_pkt;
    logic                q_full;
    logic                q_empty;
    logic                slot_free;
    logic                aw_push;
    logic                cmd_pop;
    logic                w_fire;
    logic                last_beat;

    assign aw_raw  = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK,
                      AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER};
    assign aw_word = CMD_W'(aw_raw);

    assign slot_free = !valid_q || READY;
    assign AWREADY   = !q_full && !RESET;
    assign aw_push   = AWVALID && AWREADY;
    assign cmd_pop   = (state == ST_CMD) && !q_empty && slot_free;
    assign WREADY    = (state == ST_DAT) && slot_free;
    assign w_fire    = WVALID && WREADY;
    assign last_beat = (beats == '0);

    // LAST comes from the AWLEN countdown; WLAST only feeds the error flag
    assign dat_raw = {WDATA, WSTRB, WUSER, last_beat};
    assign cmd_pkt = {PKT_CMD, (PKT_W - 1)'(cmd_word)};
    assign dat_pkt = {PKT_DAT, (PKT_W - 1)'(dat_raw)};

    aw_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (aw_push),
        .push_data (aw_word),
        .pop       (cmd_pop),
        .pop_data  (cmd_word),
        .full      (q_full),
        .empty     (q_empty),
        .level     (AW_LEVEL)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_CMD;
            beats   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cmd_pop) begin
                data_q  <= cmd_pkt;
                valid_q <= 1'b1;
                beats   <= cmd_word[USER_W + LEN_OFS +: LEN_W];
                state   <= ST_DAT;
            end else if (w_fire) begin
                data_q  <= dat_pkt;
                valid_q <= 1'b1;
                if (last_beat) begin
                    state <= ST_CMD;
                end else begin
                    beats <= beats - 1'b1;
                end
                if (WLAST != last_beat) begin
                    err_q <= 1'b1;
                end
            end else if (READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_w_forward_packer.sv
// tb/tb_w_forward_packer.sv - randomized scoreboard bench for w_forward_packer
module tb_w_forward_packer;

    localparam int PKT_W = 82;

    typedef struct {
        logic [7:0]  id;
        logic [35:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [3:0]  user;
    } aw_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [3:0]  user;
        logic        last;
    } w_t;

    logic             CLK;
    logic             RESET;
    logic [7:0]       AWID;
    logic [35:0]      AWADDR;
    logic [7:0]       AWLEN;
    logic [2:0]       AWSIZE;
    logic [1:0]       AWBURST;
    logic [0:0]       AWLOCK;
    logic [3:0]       AWCACHE;
    logic [2:0]       AWPROT;
    logic [3:0]       AWQOS;
    logic [3:0]       AWREGION;
    logic [3:0]       AWUSER;
    logic             AWVALID;
    logic             AWREADY;
    logic [63:0]      WDATA;
    logic [7:0]       WSTRB;
    logic             WLAST;
    logic [3:0]       WUSER;
    logic             WVALID;
    logic             WREADY;
    logic [PKT_W-1:0] DATA;
    logic             VALID;
    logic             READY;
    logic [2:0]       AW_LEVEL;
    logic             ERR;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               ready_mode = 0;
    int               aw_gap = 0;
    int               w_gap = 0;
    logic             exp_err = 1'b0;
    logic             stall = 1'b0;
    logic [PKT_W-1:0] held = '0;
    aw_t              aw_q[$];
    w_t               w_q[$];
    logic [PKT_W-1:0] exp_q[$];
    int               hs_q[$];

    w_forward_packer #(
        .ID_W(8), .ADDR_W(36), .DATA_W(64), .USER_W(4), .AW_DEPTH(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWQOS(AWQOS), .AWREGION(AWREGION), .AWUSER(AWUSER),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
        .WVALID(WVALID), .WREADY(WREADY),
        .DATA(DATA), .VALID(VALID), .READY(READY),
        .AW_LEVEL(AW_LEVEL), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [PKT_W-1:0] shift_in(input logic [PKT_W-1:0] p, input logic [63:0] v, input int w);
        return (p << w) | PKT_W'(v);
    endfunction

    function automatic logic [PKT_W-1:0] exp_cmd(input aw_t a);
        logic [PKT_W-1:0] p;
        p = '0;
        p = shift_in(p, 64'(a.id), 8);
        p = shift_in(p, 64'(a.addr), 36);
        p = shift_in(p, 64'(a.len), 8);
        p = shift_in(p, 64'(a.size), 3);
        p = shift_in(p, 64'(a.burst), 2);
        p = shift_in(p, 64'(a.lock), 1);
        p = shift_in(p, 64'(a.cache), 4);
        p = shift_in(p, 64'(a.prot), 3);
        p = shift_in(p, 64'(a.qos), 4);
        p = shift_in(p, 64'(a.region), 4);
        p = shift_in(p, 64'(a.user), 4);
        p[PKT_W-1] = 1'b1;
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] exp_dat(input w_t w, input logic last);
        logic [PKT_W-1:0] p;
        p = '0;
        p = shift_in(p, w.data, 64);
        p = shift_in(p, 64'(w.strb), 8);
        p = shift_in(p, 64'(w.user), 4);
        p = shift_in(p, 64'(last), 1);
        return p;
    endfunction

    function automatic aw_t rand_aw(input int len);
        aw_t a;
        a.id     = 8'($urandom());
        a.addr   = 36'({$urandom(), $urandom()});
        a.len    = 8'(len);
        a.size   = 3'($urandom());
        a.burst  = 2'($urandom());
        a.lock   = 1'($urandom());
        a.cache  = 4'($urandom());
        a.prot   = 3'($urandom());
        a.qos    = 4'($urandom());
        a.region = 4'($urandom());
        a.user   = 4'($urandom());
        return a;
    endfunction

    function automatic w_t rand_w(input logic last);
        w_t w;
        w.data = {$urandom(), $urandom()};
        w.strb = 8'($urandom());
        w.user = 4'($urandom());
        w.last = last;
        return w;
    endfunction

    task automatic add_aw(input aw_t a);
        aw_q.push_back(a);
        exp_q.push_back(exp_cmd(a));
    endtask

    // Framing LAST is dictated by the beat's position in the burst, not by WLAST
    task automatic add_beat(input w_t w, input logic last_pos);
        w_q.push_back(w);
        exp_q.push_back(exp_dat(w, last_pos));
        if (w.last != last_pos) exp_err = 1'b1;
    endtask

    task automatic gen_burst(input int len);
        add_aw(rand_aw(len));
        for (int i = 0; i <= len; i++) add_beat(rand_w(i == len), i == len);
    endtask

    task automatic put_aw(input aw_t a);
        AWID = a.id; AWADDR = a.addr; AWLEN = a.len; AWSIZE = a.size;
        AWBURST = a.burst; AWLOCK = a.lock; AWCACHE = a.cache; AWPROT = a.prot;
        AWQOS = a.qos; AWREGION = a.region; AWUSER = a.user;
        AWVALID = 1'b1;
    endtask

    task automatic send_aw(input aw_t a);
        int n;
        n = 0;
        put_aw(a);
        @(negedge CLK);
        while (!AWREADY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!AWREADY) begin
            checks++;
            failures++;
            $display("FAIL aw_timeout actual=awready_low required=awready_high");
        end
        tick();
        AWVALID = 1'b0;
        if (aw_gap > 0) repeat ($urandom_range(0, aw_gap)) tick();
    endtask

    task automatic send_w(input w_t w);
        int n;
        n = 0;
        WDATA = w.data; WSTRB = w.strb; WUSER = w.user; WLAST = w.last;
        WVALID = 1'b1;
        @(negedge CLK);
        while (!WREADY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!WREADY) begin
            checks++;
            failures++;
            $display("FAIL w_timeout actual=wready_low required=wready_high");
        end
        tick();
        WVALID = 1'b0;
        if (w_gap > 0) repeat ($urandom_range(0, w_gap)) tick();
    endtask

    task automatic drive_all();
        fork
            begin
                while (aw_q.size() > 0) send_aw(aw_q.pop_front());
            end
            begin
                while (w_q.size() > 0) send_w(w_q.pop_front());
            end
        join
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        READY = (m != 3);
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        case (ready_mode)
            0:       READY = 1'b1;
            1:       READY = 1'($urandom_range(0, 1));
            2:       READY = ~READY;
            default: READY = 1'b0;
        endcase
    end

    // Monitor: compares every accepted packet and checks output stability under stall
    initial forever begin
        @(negedge CLK);
        if (RESET) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", VALID, 1);
                check("stall_data", DATA, held);
            end
            if (VALID && READY) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pkt actual=%0h required=none", DATA);
                end else begin
                    check("pkt", DATA, exp_q.pop_front());
                end
            end
            stall = VALID && !READY;
            held  = DATA;
        end
    end

    initial begin
        aw_t a;
        w_t  w;
        int  n;

        RESET = 1'b1;
        AWVALID = 1'b0; WVALID = 1'b0; READY = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWLOCK = '0;
        AWCACHE = '0; AWPROT = '0; AWQOS = '0; AWREGION = '0; AWUSER = '0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WUSER = '0;
        ready_mode = 3;

        @(negedge CLK);
        check("rst_valid", VALID, 0);
        check("rst_data", DATA, 0);
        check("rst_wready", WREADY, 0);
        check("rst_err", ERR, 0);
        check("rst_level", AW_LEVEL, 0);
        check("rst_awready", AWREADY, 0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("awready_after_rst", AWREADY, 1);
        tick();

        // Single beat
        set_ready(0);
        a = rand_aw(0);
        a.id = 8'h12;
        a.addr = 36'h0_1000_0000;
        add_aw(a);
        w.data = 64'hDEAD_BEEF_0123_4567;
        w.strb = 8'hFF;
        w.user = 4'h0;
        w.last = 1'b1;
        add_beat(w, 1'b1);
        drive_all();
        wait_drain("single_drain");
        check("single_err", ERR, 0);

        // Queue fill under READY=0
        set_ready(3);
        aw_gap = 0;
        w_gap = 0;
        for (int i = 0; i < 6; i++) gen_burst(0);
        for (int i = 0; i < 5; i++) send_aw(aw_q.pop_front());
        @(negedge CLK);
        check("fill_level", AW_LEVEL, 4);
        check("fill_awready", AWREADY, 0);
        check("fill_valid", VALID, 1);
        tick();
        put_aw(aw_q[0]);
        repeat (3) begin
            @(negedge CLK);
            check("aw6_held", AWREADY, 0);
        end
        tick();
        set_ready(1);
        aw_gap = 2;
        w_gap = 2;
        drive_all();
        wait_drain("fill_drain");

        // Backpressure with READY toggling
        set_ready(2);
        gen_burst(3);
        drive_all();
        wait_drain("bp_drain");

        // Two pre-queued AWLEN=1 bursts at full rate
        set_ready(3);
        aw_gap = 0;
        w_gap = 0;
        tick();
        gen_burst(1);
        gen_burst(1);
        send_aw(aw_q.pop_front());
        send_aw(aw_q.pop_front());
        tick();
        tick();
        hs_q.delete();
        set_ready(0);
        while (w_q.size() > 0) send_w(w_q.pop_front());
        wait_drain("tput_drain");
        check("tput_count", hs_q.size(), 6);
        if (hs_q.size() == 6) check("tput_span", hs_q[5] - hs_q[0], 5);

        // Random traffic
        set_ready(1);
        aw_gap = 3;
        w_gap = 2;
        for (int i = 0; i < 15; i++) gen_burst($urandom_range(0, 7));
        drive_all();
        wait_drain("rand_drain");
        check("rand_err", ERR, exp_err);

        // Early WLAST on beat 1 of an AWLEN=2 burst
        set_ready(0);
        aw_gap = 0;
        w_gap = 0;
        add_aw(rand_aw(2));
        add_beat(rand_w(1'b0), 1'b0);
        add_beat(rand_w(1'b1), 1'b0);
        add_beat(rand_w(1'b1), 1'b1);
        send_aw(aw_q.pop_front());
        send_w(w_q.pop_front());
        @(negedge CLK);
        check("early_err_beat0", ERR, 0);
        tick();
        send_w(w_q.pop_front());
        @(negedge CLK);
        check("early_err_beat1", ERR, 1);
        tick();
        send_w(w_q.pop_front());
        wait_drain("early_drain");
        check("early_err_end", ERR, exp_err);

        // ERR stays sticky across further clean traffic
        set_ready(1);
        aw_gap = 1;
        w_gap = 1;
        for (int i = 0; i < 5; i++) gen_burst($urandom_range(0, 4));
        drive_all();
        wait_drain("sticky_drain");
        check("sticky_err", ERR, 1);

        // Reset after 2 of 4 beats
        set_ready(0);
        aw_gap = 0;
        w_gap = 0;
        gen_burst(3);
        send_aw(aw_q.pop_front());
        send_w(w_q.pop_front());
        send_w(w_q.pop_front());
        n = 0;
        while (exp_q.size() > 2 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("pre_rst_pkts", exp_q.size(), 2);
        tick();
        RESET = 1'b1;
        exp_q.delete();
        w_q.delete();
        aw_q.delete();
        exp_err = 1'b0;
        @(negedge CLK);
        check("midrst_valid", VALID, 0);
        check("midrst_wready", WREADY, 0);
        check("midrst_level", AW_LEVEL, 0);
        check("midrst_err", ERR, 0);
        check("midrst_awready", AWREADY, 0);
        tick();
        RESET = 1'b0;
        gen_burst(0);
        drive_all();
        wait_drain("post_rst_drain");
        check("post_rst_err", ERR, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
